// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer stepping FETCH/DECODE/EXEC/MEM/WB over one variable-latency memory port.
// Optional feature: define MULTICYCLE_CTRL_JUMP_EN to accept JAL/JALR and add the JumpLink_out port.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [6:0] Opcode_in,
  input  logic       Zero_in,
  input  logic       Mem_ready_in,
  output logic       IMemReq_out,
  output logic       DMemReq_out,
  output logic       MemWrite_out,
  output logic       MemRead_out,
  output logic       IrWrite_out,
  output logic       PcWrite_out,
  output logic       PcSrc_out,
  output logic       RegWrite_out,
  output logic       MemtoReg_out,
  output logic [1:0] AluOp_out,
  output logic       AluSrc_out,
  output logic [2:0] State_out,
  output logic       Instret_out,
`ifdef MULTICYCLE_CTRL_JUMP_EN
  output logic       JumpLink_out,
`endif
  output logic       Trap_out
);

  // state  | meaning
  // FETCH  | instruction request pending, IR/PC load on ready
  // DECODE | capture opcode, reject illegal encodings
  // EXEC   | ALU phase; branches resolve and retire here
  // MEM    | data request pending (LW/SW)
  // WB     | register write-back, retire
  // TRAP   | absorbing fault, only reset leaves
  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
`ifdef MULTICYCLE_CTRL_JUMP_EN
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
`endif
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [6:0]      opc_q, opc_d;
  logic            is_r, is_i, is_lw, is_sw, is_b, is_j, legal_in, wait_last;

  always_comb begin
    is_r      = (opc_q == OP_R);
    is_i      = (opc_q == OP_I);
    is_lw     = (opc_q == OP_LW);
    is_sw     = (opc_q == OP_SW);
    is_b      = (opc_q == OP_B);
    wait_last = (cnt_q == WAIT_LAST);
    legal_in  = (Opcode_in == OP_R) || (Opcode_in == OP_I) || (Opcode_in == OP_LW) ||
                (Opcode_in == OP_SW) || (Opcode_in == OP_B);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    is_j      = (opc_q == OP_JAL) || (opc_q == OP_JALR);
    legal_in  = legal_in || (Opcode_in == OP_JAL) || (Opcode_in == OP_JALR);
`else
    is_j      = 1'b0;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
    end
  end

  assign State_out = state_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opc_d        = opc_q;
    IMemReq_out  = 1'b0;
    DMemReq_out  = 1'b0;
    MemWrite_out = 1'b0;
    MemRead_out  = 1'b0;
    IrWrite_out  = 1'b0;
    PcWrite_out  = 1'b0;
    PcSrc_out    = 1'b0;
    RegWrite_out = 1'b0;
    MemtoReg_out = 1'b0;
    AluOp_out    = 2'b00;
    AluSrc_out   = 1'b0;
    Instret_out  = 1'b0;
    Trap_out     = 1'b0;
`ifdef MULTICYCLE_CTRL_JUMP_EN
    JumpLink_out = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        IMemReq_out = 1'b1;
        if (Mem_ready_in) begin
          IrWrite_out = 1'b1;
          PcWrite_out = 1'b1;
          state_d     = S_DECODE;
        end else if (wait_last) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        opc_d   = Opcode_in;
        state_d = legal_in ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        AluOp_out  = is_r ? 2'b10 : (is_b ? 2'b01 : 2'b00);
        AluSrc_out = is_i || is_lw || is_sw || is_j;
        if (is_r || is_i || is_j) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else if (is_b) begin
          PcWrite_out = Zero_in;
          PcSrc_out   = Zero_in;
          Instret_out = 1'b1;
          state_d     = S_FETCH;
          cnt_d       = '0;
        end else begin
          state_d = S_TRAP;
        end
        if (is_j) begin
          PcWrite_out = 1'b1;
          PcSrc_out   = 1'b1;
        end
      end
      S_MEM: begin
        DMemReq_out  = 1'b1;
        MemRead_out  = is_lw;
        MemWrite_out = is_sw;
        AluSrc_out   = 1'b1;
        if (Mem_ready_in) begin
          if (is_sw) begin
            Instret_out = 1'b1;
            state_d     = S_FETCH;
            cnt_d       = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_last) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_WB: begin
        RegWrite_out = 1'b1;
        MemtoReg_out = !is_lw;
        Instret_out  = 1'b1;
`ifdef MULTICYCLE_CTRL_JUMP_EN
        JumpLink_out = is_j;
`endif
        state_d      = S_FETCH;
        cnt_d        = '0;
      end
      S_TRAP: begin
        Trap_out = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
    // Reset parks the state in FETCH; keep the request and every pulse quiet until release.
    if (!rst_n_in) begin
      IMemReq_out  = 1'b0;
      DMemReq_out  = 1'b0;
      MemWrite_out = 1'b0;
      MemRead_out  = 1'b0;
      IrWrite_out  = 1'b0;
      PcWrite_out  = 1'b0;
      PcSrc_out    = 1'b0;
      RegWrite_out = 1'b0;
      MemtoReg_out = 1'b0;
      AluOp_out    = 2'b00;
      AluSrc_out   = 1'b0;
      Instret_out  = 1'b0;
      Trap_out     = 1'b0;
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JumpLink_out = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model expands each instruction into its expected per-cycle outputs.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  localparam int TO = 16;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst_n_in, Zero_in, Mem_ready_in;
  logic [6:0] Opcode_in;
  logic       IMemReq_out, DMemReq_out, MemWrite_out, MemRead_out, IrWrite_out, PcWrite_out;
  logic       PcSrc_out, RegWrite_out, MemtoReg_out, AluSrc_out, Instret_out, Trap_out, jl;
  logic [1:0] AluOp_out;
  logic [2:0] State_out;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .Opcode_in(Opcode_in), .Zero_in(Zero_in),
    .Mem_ready_in(Mem_ready_in), .IMemReq_out(IMemReq_out), .DMemReq_out(DMemReq_out),
    .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out), .IrWrite_out(IrWrite_out),
    .PcWrite_out(PcWrite_out), .PcSrc_out(PcSrc_out), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .AluOp_out(AluOp_out), .AluSrc_out(AluSrc_out),
    .State_out(State_out), .Instret_out(Instret_out),
`ifdef MULTICYCLE_CTRL_JUMP_EN
    .JumpLink_out(jl),
`endif
    .Trap_out(Trap_out)
  );
`ifndef MULTICYCLE_CTRL_JUMP_EN
  assign jl = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic imem, dmem, mw, mr, irw, pcw, pcs, rw, m2r;
    logic [1:0] aop;
    logic asrc, iret, trap, jl;
  } out_t;

  // per-instruction plan: expected outputs plus the inputs to drive in that cycle
  out_t       plan_e[$];
  logic       plan_r[$], plan_z[$];
  logic [6:0] plan_o[$];
  string      plan_n[$];
  bit         plan_trap;

  out_t  sb_e[$];
  string sb_n[$];
  int    total = 0, bad = 0;

  always @(negedge clk) begin
    out_t a, e;
    string n;
    a = {State_out, IMemReq_out, DMemReq_out, MemWrite_out, MemRead_out, IrWrite_out, PcWrite_out,
         PcSrc_out, RegWrite_out, MemtoReg_out, AluOp_out, AluSrc_out, Instret_out, Trap_out, jl};
    if (sb_e.size() > 0) begin
      e = sb_e.pop_front();
      n = sb_n.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s @%0t: got=%b (st=%0d) expected=%b (st=%0d)", n, $time, a, a.st, e, e.st);
      end
    end
  end

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic bit is_jump(input logic [6:0] op);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    return (op == OP_JAL) || (op == OP_JALR);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) || (op == OP_B) || is_jump(op);
  endfunction

  task automatic add(input out_t o, input logic r, input logic z, input logic [6:0] op, input string n);
    plan_e.push_back(o); plan_r.push_back(r); plan_z.push_back(z);
    plan_o.push_back(op); plan_n.push_back(n);
  endtask

  task automatic add_trap(input int n);
    out_t o;
    o = '0; o.st = 3'd5; o.trap = 1'b1;
    for (int k = 0; k < n; k++) add(o, rb(), rb(), 7'($urandom), "trap");
    plan_trap = 1'b1;
  endtask

  // Expand one instruction: fw / mwt are the cycles the memory withholds ready (>= TO means never).
  task automatic build(input logic [6:0] op, input int fw, input int mwt, input logic z);
    out_t o;
    bit lw, sw, j;
    plan_e.delete(); plan_r.delete(); plan_z.delete(); plan_o.delete(); plan_n.delete();
    plan_trap = 1'b0;
    lw = (op == OP_LW); sw = (op == OP_SW); j = is_jump(op);
    for (int k = 0; k <= fw && k < TO; k++) begin
      o = '0; o.st = 3'd0; o.imem = 1'b1;
      if (k == fw) begin o.irw = 1'b1; o.pcw = 1'b1; end
      add(o, k == fw, rb(), 7'($urandom), "fetch");
    end
    if (fw >= TO) begin add_trap(3); return; end
    o = '0; o.st = 3'd1;
    add(o, rb(), rb(), op, "decode");
    if (!legal(op)) begin add_trap(3); return; end
    o = '0; o.st = 3'd2;
    o.aop  = (op == OP_R) ? 2'b10 : (op == OP_B) ? 2'b01 : 2'b00;
    o.asrc = (op == OP_I) || lw || sw || j;
    if (op == OP_B) begin o.pcw = z; o.pcs = z; o.iret = 1'b1; end
    if (j) begin o.pcw = 1'b1; o.pcs = 1'b1; end
    add(o, rb(), z, op, "exec");
    if (op == OP_B) return;
    if (lw || sw) begin
      for (int k = 0; k <= mwt && k < TO; k++) begin
        o = '0; o.st = 3'd3; o.dmem = 1'b1; o.mr = lw; o.mw = sw; o.asrc = 1'b1;
        o.iret = sw && (k == mwt);
        add(o, k == mwt, rb(), op, "mem");
      end
      if (mwt >= TO) begin add_trap(3); return; end
      if (sw) return;
    end
    o = '0; o.st = 3'd4; o.rw = 1'b1; o.m2r = !lw; o.jl = j; o.iret = 1'b1;
    add(o, rb(), rb(), op, "wb");
  endtask

  // Issue the first `cut` cycles of the plan (all of it when cut < 0).
  task automatic run(input int cut);
    int n;
    n = (cut < 0 || cut > plan_e.size()) ? plan_e.size() : cut;
    for (int k = 0; k < n; k++) begin sb_e.push_back(plan_e[k]); sb_n.push_back(plan_n[k]); end
    for (int k = 0; k < n; k++) begin
      Opcode_in = plan_o[k]; Mem_ready_in = plan_r[k]; Zero_in = plan_z[k];
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin sb_e.push_back('0); sb_n.push_back("reset"); end
    rst_n_in = 1'b0;
    for (int k = 0; k < n; k++) begin
      Mem_ready_in = 1'b1; Zero_in = rb(); Opcode_in = 7'($urandom);
      @(posedge clk); #1;
    end
    rst_n_in = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [8];
    logic [6:0] op;
    int fw, mwt, cut;
    ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_JAL, OP_JALR, 7'h00};
    rst_n_in = 1'b0; Opcode_in = '0; Zero_in = 1'b0; Mem_ready_in = 1'b0;
    @(posedge clk); #1;
    do_reset(3);
    for (int k = 0; k < 3; k++) begin build(OP_R, 0, 0, 1'b0); run(-1); end
    build(OP_LW, 0, 3, 1'b0); run(-1);
    build(OP_B, 0, 0, 1'b1); run(-1);
    build(OP_B, 1, 0, 1'b0); run(-1);
    build(OP_SW, 2, 1, 1'b0); run(-1);
    build(OP_I, TO - 1, 0, 1'b0); run(-1);
    build(OP_LW, 0, TO - 1, 1'b0); run(-1);
    build(OP_R, TO, 0, 1'b0); run(-1); do_reset(2);
    build(7'h7f, 0, 0, 1'b0); run(-1); do_reset(2);
    build(OP_SW, 0, TO, 1'b0); run(-1); do_reset(2);
    build(OP_JAL, 1, 0, 1'b0); run(-1); do_reset(2);
    build(OP_LW, 0, 5, 1'b0); run(5); do_reset(2);
    for (int t = 0; t < 200; t++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 7'h00) op = 7'($urandom);
      fw  = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 3);
      mwt = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 4);
      build(op, fw, mwt, rb());
      cut = ($urandom_range(0, 11) == 0) ? $urandom_range(1, plan_e.size()) : -1;
      run(cut);
      if (plan_trap || cut >= 0) do_reset($urandom_range(1, 3));
    end
    total++;
    if (sb_e.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_e.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core. It replaces single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives instruction/data memory request handshakes and the PC/IR write enables, and issues the datapath controls (RegWrite, MemWrite, MemRead, MemtoReg, AluOp, AluSrc) one phase at a time.
- Sits between the instruction register/opcode field and the shared datapath plus a single memory port with variable latency.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for Mem_ready_in per access before trapping (legal range 2..255).
- TO_W, 8, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk_in  input  1  core clock, rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- Opcode_in  input  7  opcode field of the IR, valid from DECODE onward.
- Zero_in  input  1  ALU branch condition (1 = taken), sampled in EXEC.
- Mem_ready_in  input  1  memory port completes the current request this cycle.
- IMemReq_out  output  1  instruction fetch request.
- DMemReq_out  output  1  data access request.
- MemWrite_out  output  1  data write (with DMemReq_out).
- MemRead_out  output  1  data read (with DMemReq_out).
- IrWrite_out  output  1  load IR.
- PcWrite_out  output  1  update PC.
- PcSrc_out  output  1  0 = PC+4, 1 = branch target.
- RegWrite_out  output  1  register file write.
- MemtoReg_out  output  1  0 = memory data, 1 = ALU result.
- AluOp_out  output  2  00 add, 01 branch compare, 10 funct-decoded.
- AluSrc_out  output  1  0 = rs2, 1 = immediate.
- State_out  output  3  current state encoding.
- Instret_out  output  1  one-cycle pulse per retired instruction.
- Trap_out  output  1  sticky fault (illegal opcode or memory timeout).

Behaviour:
- Reset (rst_n_in low, asynchronous): state = FETCH (000), wait counter = 0, opcode register = 0, Trap_out = 0.
  - All outputs are 0 while in reset, except IMemReq_out, which follows FETCH as soon as reset releases.
- State encodings: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, TRAP 101. Codes 110 and 111 go to TRAP.
- Outputs are Moore: decoded from the state and the registered opcode only. Zero_in and Mem_ready_in are the exceptions: they gate the completion pulses.
- FETCH:
  - IMemReq_out = 1 held until Mem_ready_in = 1.
  - On the ready cycle, IrWrite_out = 1 and PcWrite_out = 1 with PcSrc_out = 0; next state DECODE.
- DECODE (1 cycle): register Opcode_in.
  - Legal opcodes: 0110011 R, 0010011 I, 0000011 LW, 0100011 SW, 1100011 B. A legal opcode goes to EXEC.
  - Any other opcode goes to TRAP.
- EXEC (1 cycle):
  - AluOp_out = 10 for R, 00 for I/LW/SW, 01 for B.
  - AluSrc_out = 1 for I/LW/SW, 0 for R/B.
  - R/I go to WB. LW/SW go to MEM.
  - B: if Zero_in = 1, PcWrite_out = 1 and PcSrc_out = 1. The next state is FETCH whether or not the branch is taken, and Instret_out pulses.
- MEM: DMemReq_out = 1; MemRead_out = 1 for LW, MemWrite_out = 1 for SW. AluOp_out and AluSrc_out keep their EXEC values.
  - On Mem_ready_in: LW goes to WB; SW goes to FETCH and pulses Instret_out.
- WB (1 cycle): RegWrite_out = 1; MemtoReg_out = 0 for LW, 1 for R/I; next state FETCH; Instret_out pulses.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle the request is pending without ready.
  - If the count reaches MEM_TIMEOUT with no ready, go to TRAP. Ready arriving on that same cycle wins: the access completes normally.
- TRAP: absorbing state.
  - Trap_out = 1; all enables, requests and pulses are 0.
  - Only reset exits TRAP.
- Reset asserted mid-access drops the request immediately. No partial PC, IR or register write may occur.
- CPI: R/I = 4 + fetch wait; LW = 5 + waits; SW = 4 + waits; B = 3 + fetch wait. Each memory access with zero wait completes in 1 cycle.

Optional Feature:
- Macro MULTICYCLE_CTRL_JUMP_EN.
- Defined:
  - Opcodes 1101111 (JAL) and 1100111 (JALR) are legal and add output JumpLink_out (1 bit).
  - JAL/JALR sequence: EXEC asserts PcWrite_out = 1, PcSrc_out = 1, AluSrc_out = 1 and AluOp_out = 00, then goes to WB.
  - In WB: RegWrite_out = 1, JumpLink_out = 1 (write-back selects PC+4), MemtoReg_out = 1.
- Undefined: no JumpLink_out port; both opcodes go to TRAP.

Test Plan:
- Reset, then release with Mem_ready_in tied to 1 and Opcode_in = 0110011 → State_out 000,001,010,100,000. IrWrite_out and PcWrite_out are high in cycle 0, AluOp_out = 10 in EXEC, RegWrite_out = 1 and MemtoReg_out = 1 in WB, Instret_out pulses once per 4 cycles.
- LW (0000011) with data ready delayed by 3 cycles → DMemReq_out and MemRead_out held for 4 cycles. WB then shows MemtoReg_out = 0 and RegWrite_out = 1; total 8 cycles.
- Branches with opcode 1100011: Zero_in = 1 in EXEC → PcWrite_out = 1 and PcSrc_out = 1 for 1 cycle, then FETCH. Zero_in = 0 → PcWrite_out stays 0 and no RegWrite_out occurs.
- SW (0100011) → MemWrite_out = 1 only in MEM, RegWrite_out is never asserted, returns to FETCH after ready.
- Timeouts and illegal opcodes:
  - With MEM_TIMEOUT = 16 and Mem_ready_in held at 0 in FETCH: TRAP (101) on the 17th cycle and Trap_out stays 1.
  - Opcode 1111111: TRAP straight from DECODE.
  - Asserting rst_n_in low recovers to FETCH with Trap_out = 0.
- Macro defined: JAL (1101111) → PcWrite_out = 1 and PcSrc_out = 1 in EXEC, then JumpLink_out = 1 and RegWrite_out = 1 in WB. Macro undefined: the same opcode goes to TRAP.
